// File: rtl/sga_pkg.sv
// Shared definitions for the graphics pipeline: framebuffer geometry defaults,
// plotter queue depth and the plotter FSM encoding.
package sga_pkg;

   localparam int FB_W_DEF    = 160;
   localparam int FB_H_DEF    = 120;
   localparam int ADDR_W_DEF  = 15;
   localparam int COLOR_W_DEF = 3;
   localparam int COORD_W     = 8;
   localparam int FIFO_DEPTH  = 4;
   localparam int FIFO_PTR_W  = $clog2(FIFO_DEPTH);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } plot_state_t;

   function automatic logic in_frame(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input int                 fb_w,
                                     input int                 fb_h);
      return (int'(x) < fb_w) && (int'(y) < fb_h);
   endfunction

endpackage

// File: rtl/pix_fifo.sv
// Four-deep synchronous FIFO holding pixels between the drawers and the
// framebuffer write port. Head entry is visible on rd_data while not empty.
module pix_fifo
   import sga_pkg::*;
#(
   parameter int DATA_W = 20
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0]     mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr;
   logic [FIFO_PTR_W-1:0] rd_ptr;
   logic [FIFO_PTR_W:0]   count;
   logic                  push_ok;
   logic                  pop_ok;

   assign full    = (count == (FIFO_PTR_W+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_plotter.sv
// Pixel plotter: queues drawer pixels, clips them against the framebuffer and
// issues one held write per in-frame pixel until the memory acknowledges it.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no write pending; pops the queue head whenever one is present
// ST_WRITE | MEM_WE held with address/data stable, waiting for MEM_ACK
module pixel_plotter
   import sga_pkg::*;
#(
   parameter int FB_W    = FB_W_DEF,
   parameter int FB_H    = FB_H_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int COLOR_W = COLOR_W_DEF
) (
   input  logic               ACLK,
   input  logic               RST,
   input  logic               EN,
   input  logic [7:0]         X_In,
   input  logic [7:0]         Y_In,
   input  logic [COLOR_W-1:0] COLOR,
   input  logic               LAST_In,
   input  logic               IN_VALID,
   output logic               IN_READY,
   output logic [ADDR_W-1:0]  MEM_ADDR,
   output logic [COLOR_W-1:0] MEM_DATA,
   output logic               MEM_WE,
   input  logic               MEM_ACK,
   output logic               DONE,
   output logic               BUSY,
   output logic [7:0]         CLIP_CNT
);

   localparam int ENTRY_W = 2*COORD_W + COLOR_W + 1;

   plot_state_t         state;
   plot_state_t         state_nxt;
   logic [ENTRY_W-1:0]  fifo_wr;
   logic [ENTRY_W-1:0]  fifo_rd;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;

   logic [COORD_W-1:0]  head_x;
   logic [COORD_W-1:0]  head_y;
   logic [COLOR_W-1:0]  head_col;
   logic                head_last;
   logic                head_in_frame;
   logic [ADDR_W-1:0]   head_addr;

   logic                last_r;
   logic                last_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [COLOR_W-1:0]  data_nxt;
   logic                we_nxt;
   logic                done_nxt;
   logic [7:0]          clip_nxt;

   // A full queue refuses input even in the cycle it pops.
   assign IN_READY  = EN && !fifo_full && !RST;
   assign fifo_push = IN_VALID && IN_READY;
   assign fifo_wr   = {X_In, Y_In, COLOR, LAST_In};
   assign BUSY      = !RST && (!fifo_empty || (state == ST_WRITE));

   pix_fifo #(
      .DATA_W (ENTRY_W)
   ) u_pix_fifo (
      .clk_sys (ACLK),
      .rst     (RST),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (fifo_wr),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head_x        = fifo_rd[ENTRY_W-1 -: COORD_W];
   assign head_y        = fifo_rd[ENTRY_W-COORD_W-1 -: COORD_W];
   assign head_col      = fifo_rd[COLOR_W:1];
   assign head_last     = fifo_rd[0];
   assign head_in_frame = in_frame(head_x, head_y, FB_W, FB_H);
   // Clipping guarantees the row-major address fits in ADDR_W.
   assign head_addr     = ADDR_W'(head_y) * ADDR_W'(FB_W) + ADDR_W'(head_x);

   always_comb begin
      state_nxt = state;
      addr_nxt  = MEM_ADDR;
      data_nxt  = MEM_DATA;
      we_nxt    = MEM_WE;
      last_nxt  = last_r;
      clip_nxt  = CLIP_CNT;
      done_nxt  = 1'b0;
      fifo_pop  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (!head_in_frame) begin
                  if (CLIP_CNT != 8'hFF) begin
                     clip_nxt = CLIP_CNT + 8'd1;
                  end
                  done_nxt = head_last;
               end else begin
                  addr_nxt  = head_addr;
                  data_nxt  = head_col;
                  we_nxt    = 1'b1;
                  last_nxt  = head_last;
                  state_nxt = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (MEM_ACK) begin
               we_nxt    = 1'b0;
               done_nxt  = last_r;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            we_nxt    = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         MEM_ADDR <= '0;
         MEM_DATA <= '0;
         MEM_WE   <= 1'b0;
         last_r   <= 1'b0;
         DONE     <= 1'b0;
         CLIP_CNT <= '0;
      end else begin
         state    <= state_nxt;
         MEM_ADDR <= addr_nxt;
         MEM_DATA <= data_nxt;
         MEM_WE   <= we_nxt;
         last_r   <= last_nxt;
         DONE     <= done_nxt;
         CLIP_CNT <= clip_nxt;
      end
   end

endmodule

// File: tb/tb_pixel_plotter.sv
// Bench for pixel_plotter: directed scenarios plus randomized traffic checked
// against a transaction-level model of accepted pixels and expected writes.
module tb_pixel_plotter;

   logic        ACLK = 1'b0;
   logic        RST;
   logic        EN;
   logic [7:0]  X_In;
   logic [7:0]  Y_In;
   logic [2:0]  COLOR;
   logic        LAST_In;
   logic        IN_VALID;
   logic        IN_READY;
   logic [14:0] MEM_ADDR;
   logic [2:0]  MEM_DATA;
   logic        MEM_WE;
   logic        MEM_ACK;
   logic        DONE;
   logic        BUSY;
   logic [7:0]  CLIP_CNT;

   pixel_plotter dut (
      .ACLK     (ACLK),
      .RST      (RST),
      .EN       (EN),
      .X_In     (X_In),
      .Y_In     (Y_In),
      .COLOR    (COLOR),
      .LAST_In  (LAST_In),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .MEM_ADDR (MEM_ADDR),
      .MEM_DATA (MEM_DATA),
      .MEM_WE   (MEM_WE),
      .MEM_ACK  (MEM_ACK),
      .DONE     (DONE),
      .BUSY     (BUSY),
      .CLIP_CNT (CLIP_CNT)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      int addr;
      int col;
      bit last;
   } wr_t;

   wr_t wq[$];
   int  checks = 0;
   int  errors = 0;
   int  exp_clip = 0;
   int  exp_done = 0;
   int  obs_done = 0;
   int  wr_count = 0;
   int  last_wr_addr = -1;
   bit  done_due = 1'b0;
   int  ack_mode = 0;
   bit  rand_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(negedge ACLK);
      case (ack_mode)
         0:       MEM_ACK = 1'b0;
         1:       MEM_ACK = 1'b1;
         default: MEM_ACK = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic peek();
      #2;
   endtask

   // Reference model: every accepted pixel is either clipped or becomes one
   // write, in acceptance order; LAST pixels each produce one DONE.
   always @(negedge ACLK) begin
      #2;
      if (RST) begin
         wq.delete();
         exp_clip = 0;
         exp_done = 0;
         obs_done = 0;
         done_due = 1'b0;
      end else begin
         if (done_due) begin
            check("done_after_ack", 32'(DONE), 1);
            done_due = 1'b0;
         end
         if (DONE) obs_done++;
         if (MEM_WE) begin
            if (wq.size() == 0) begin
               check("spurious_we", 32'(MEM_WE), 0);
            end else begin
               check("wr_addr", 32'(MEM_ADDR), wq[0].addr);
               check("wr_data", 32'(MEM_DATA), wq[0].col);
               if (MEM_ACK) begin
                  done_due     = wq[0].last;
                  last_wr_addr = int'(MEM_ADDR);
                  wr_count++;
                  void'(wq.pop_front());
               end
            end
         end
         if (IN_VALID && IN_READY) begin
            if (LAST_In) exp_done++;
            if (int'(X_In) >= 160 || int'(Y_In) >= 120) begin
               if (exp_clip < 255) exp_clip++;
            end else begin
               wq.push_back('{int'(Y_In) * 160 + int'(X_In), int'(COLOR), LAST_In});
            end
         end
      end
   end

   task automatic do_reset();
      tick();
      RST = 1'b1;
      IN_VALID = 1'b0;
      EN = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic send(input int x, input int y, input int c, input bit last, output int waits);
      int n = 0;
      tick();
      if (rand_en) EN = ($urandom_range(0, 3) != 0);
      X_In = 8'(x);
      Y_In = 8'(y);
      COLOR = 3'(c);
      LAST_In = last;
      IN_VALID = 1'b1;
      peek();
      while (!IN_READY && n < 300) begin
         tick();
         if (rand_en) EN = ($urandom_range(0, 3) != 0);
         peek();
         n++;
      end
      if (n >= 300) check("send_timeout", 32'(n), 0);
      waits = n;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      tick();
      IN_VALID = 1'b0;
      EN = 1'b1;
      peek();
      while (BUSY && n < 400) begin
         tick();
         peek();
         n++;
      end
      if (n >= 400) check({tag, "_drain_timeout"}, 32'(BUSY), 0);
      tick();
      peek();
      tick();
      peek();
   endtask

   task automatic end_checks(input string tag);
      check({tag, "_clip_cnt"}, 32'(CLIP_CNT), exp_clip);
      check({tag, "_done_cnt"}, obs_done, exp_done);
      check({tag, "_all_written"}, wq.size(), 0);
   endtask

   initial begin
      int w;
      int wr0;
      int px[$];
      int py[$];
      RST = 1'b1; EN = 1'b1; IN_VALID = 1'b0; X_In = '0; Y_In = '0;
      COLOR = '0; LAST_In = 1'b0; MEM_ACK = 1'b0;

      // reset state
      tick(); tick(); peek();
      check("rst_we", 32'(MEM_WE), 0);
      check("rst_addr", 32'(MEM_ADDR), 0);
      check("rst_data", 32'(MEM_DATA), 0);
      check("rst_done", 32'(DONE), 0);
      check("rst_clip", 32'(CLIP_CNT), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_ready", 32'(IN_READY), 0);
      tick();
      RST = 1'b0;

      // single pixel, ack tied high
      do_reset();
      ack_mode = 1;
      send(10, 2, 5, 1'b1, w);
      tick(); IN_VALID = 1'b0; peek();
      check("single_we_pre", 32'(MEM_WE), 0);
      check("single_busy", 32'(BUSY), 1);
      tick(); peek();
      check("single_we", 32'(MEM_WE), 1);
      check("single_addr", 32'(MEM_ADDR), 330);
      check("single_data", 32'(MEM_DATA), 5);
      check("single_done_early", 32'(DONE), 0);
      tick(); peek();
      check("single_we_off", 32'(MEM_WE), 0);
      check("single_done", 32'(DONE), 1);
      tick(); peek();
      check("single_done_pulse", 32'(DONE), 0);
      check("single_idle", 32'(BUSY), 0);
      end_checks("single");

      // six back-to-back pixels with ack held low
      do_reset();
      ack_mode = 0;
      wr0 = wr_count;
      for (int i = 0; i < 5; i++) begin
         send(i * 3, 10 + i, i, 1'b0, w);
         check("b2b_accept", w, 0);
      end
      tick();
      X_In = 8'd20; Y_In = 8'd30; COLOR = 3'd6; LAST_In = 1'b1; IN_VALID = 1'b1;
      peek();
      check("b2b_full", 32'(IN_READY), 0);
      for (int k = 0; k < 5; k++) begin
         tick(); peek();
         check("b2b_hold", 32'(IN_READY), 0);
      end
      ack_mode = 1;
      w = 0;
      do begin
         tick(); peek(); w++;
      end while (!IN_READY && w < 20);
      check("b2b_refill_lat", w, 3);
      drain("b2b");
      end_checks("b2b");
      check("b2b_writes", wr_count - wr0, 6);

      // clipped then far-corner pixel
      do_reset();
      ack_mode = 2;
      send(200, 5, 3, 1'b0, w);
      send(159, 119, 6, 1'b1, w);
      drain("clip");
      end_checks("clip");
      check("clip_one", 32'(CLIP_CNT), 1);
      check("clip_corner_addr", last_wr_addr, 19199);

      // clipped LAST pixel
      do_reset();
      ack_mode = 1;
      send(0, 130, 2, 1'b1, w);
      tick(); IN_VALID = 1'b0; peek();
      check("clast_we0", 32'(MEM_WE), 0);
      check("clast_done0", 32'(DONE), 0);
      tick(); peek();
      check("clast_we1", 32'(MEM_WE), 0);
      check("clast_done1", 32'(DONE), 1);
      check("clast_clip", 32'(CLIP_CNT), 1);
      tick(); peek();
      check("clast_done2", 32'(DONE), 0);
      check("clast_busy", 32'(BUSY), 0);
      end_checks("clast");

      // reset during a write with three entries queued
      do_reset();
      ack_mode = 0;
      for (int i = 0; i < 4; i++) send(40 + i, 7, i + 1, 1'b0, w);
      tick();
      IN_VALID = 1'b0;
      RST = 1'b1;
      peek();
      check("mrst_we_held", 32'(MEM_WE), 1);
      check("mrst_ready", 32'(IN_READY), 0);
      check("mrst_busy_in_rst", 32'(BUSY), 0);
      tick();
      RST = 1'b0;
      ack_mode = 1;
      peek();
      check("mrst_we", 32'(MEM_WE), 0);
      check("mrst_busy", 32'(BUSY), 0);
      wr0 = wr_count;
      for (int k = 0; k < 10; k++) begin
         tick(); peek();
      end
      check("mrst_no_we", 32'(MEM_WE), 0);
      check("mrst_still_idle", 32'(BUSY), 0);
      check("mrst_no_writes", wr_count - wr0, 0);

      // midpoint circle at (80,60) r=5, 8-way symmetric
      begin
         int cx = 80, cy = 60, x = 0, y = 5, d = -4;
         while (x <= y) begin
            px.push_back(cx + x); py.push_back(cy + y);
            px.push_back(cx - x); py.push_back(cy + y);
            px.push_back(cx + x); py.push_back(cy - y);
            px.push_back(cx - x); py.push_back(cy - y);
            px.push_back(cx + y); py.push_back(cy + x);
            px.push_back(cx - y); py.push_back(cy + x);
            px.push_back(cx + y); py.push_back(cy - x);
            px.push_back(cx - y); py.push_back(cy - x);
            x++;
            if (d < 0) d += 2 * x + 1;
            else begin
               y--;
               d += 2 * (x - y) + 1;
            end
         end
      end
      do_reset();
      ack_mode = 2;
      wr0 = wr_count;
      foreach (px[i]) send(px[i], py[i], 4, (i == px.size() - 1), w);
      drain("circle");
      end_checks("circle");
      check("circle_done_once", obs_done, 1);
      check("circle_no_clip", 32'(CLIP_CNT), 0);
      check("circle_writes", wr_count - wr0, px.size());

      // random traffic with stalls, EN toggling and frame-edge coordinates
      do_reset();
      ack_mode = 2;
      rand_en = 1'b1;
      send(159, 0, 1, 1'b0, w);
      send(160, 0, 2, 1'b0, w);
      send(0, 120, 3, 1'b0, w);
      send(0, 119, 4, 1'b1, w);
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            tick();
            IN_VALID = 1'b0;
         end
         send($urandom_range(0, 220), $urandom_range(0, 150), $urandom_range(0, 7),
              (i == 79) || ($urandom_range(0, 7) == 0), w);
      end
      rand_en = 1'b0;
      drain("rand");
      end_checks("rand");

      // clip counter saturation
      do_reset();
      ack_mode = 1;
      for (int i = 0; i < 260; i++) send(160 + (i % 90), i % 120, 1, (i == 259), w);
      drain("sat");
      end_checks("sat");
      check("sat_255", 32'(CLIP_CNT), 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
